// File: rtl/cache_defs_pkg.sv
// cache_defs_pkg: line geometry, field bit positions and refill FSM states shared by the instruction and data caches
package cache_defs_pkg;
  localparam int TAG_W     = 20;
  localparam int IDX_W     = 8;
  localparam int LINE_W    = TAG_W + 1 + 4 * 32;
  localparam int CL_TAG_HI = LINE_W - 1;
  localparam int CL_TAG_LO = LINE_W - TAG_W;
  localparam int CL_V      = 128;
  localparam int CL_L0_HI  = 127;
  localparam int CL_L0_LO  = 96;
  localparam int CL_L1_HI  = 95;
  localparam int CL_L1_LO  = 64;
  localparam int CL_L2_HI  = 63;
  localparam int CL_L2_LO  = 32;
  localparam int CL_L3_HI  = 31;
  localparam int CL_L3_LO  = 0;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_COMMIT = 2'd2
  } fill_state_e;
endpackage

// File: rtl/cache_line_assembler.sv
// cache_line_assembler: four 32-bit slots written by word offset (wr_*), packed into a registered line {tag,V,L0..L3} on commit_i
module cache_line_assembler
  import cache_defs_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [1:0]        wr_off_i,
  input  logic [31:0]       wr_data_i,
  input  logic              commit_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic [LINE_W-1:0] line_o
);
  logic [3:0][31:0]  slot_q, slot_d;
  logic [LINE_W-1:0] line_q, line_d;
  always_comb begin
    slot_d = slot_q;
    if (wr_en_i) slot_d[wr_off_i] = wr_data_i;
    line_d = '0;
    line_d[CL_TAG_HI:CL_TAG_LO] = tag_i;
    line_d[CL_V] = 1'b1;
    line_d[CL_L0_HI:CL_L0_LO] = slot_d[0];
    line_d[CL_L1_HI:CL_L1_LO] = slot_d[1];
    line_d[CL_L2_HI:CL_L2_LO] = slot_d[2];
    line_d[CL_L3_HI:CL_L3_LO] = slot_d[3];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q <= '0;
      line_q <= '0;
    end else begin
      slot_q <= slot_d;
      if (commit_i) line_q <= line_d;
    end
  end
  assign line_o = line_q;
endmodule

// File: rtl/insn_line_fill.sv
// insn_line_fill: I-cache miss refill (miss_* in, bus_* beats in wrap order, cw_* early critical word, fill_* line write or error)
module insn_line_fill
  import cache_defs_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              miss_req_i,
  input  logic [31:0]       miss_addr_i,
  output logic              miss_ack_o,
  output logic              busy_o,
  output logic              bus_req_o,
  output logic [31:0]       bus_addr_o,
  input  logic              bus_ack_i,
  input  logic [31:0]       bus_data_i,
  input  logic              bus_err_i,
  output logic              cw_valid_o,
  output logic [31:0]       cw_data_o,
  output logic              fill_valid_o,
  output logic [IDX_W-1:0]  fill_index_o,
  output logic [LINE_W-1:0] fill_line_o,
  output logic              fill_err_o
);
  fill_state_e      state_q;
  logic [27:0]      addr_q;
  logic [1:0]       s_q, k_q, off;
  logic             bus_req_q, cw_valid_q, fill_valid_q, fill_err_q, beat_ok;
  logic [31:0]      bus_addr_q, cw_data_q;
  logic [IDX_W-1:0] fill_index_q;
  assign off        = s_q + k_q;
  assign beat_ok    = state_q == ST_FETCH && bus_ack_i && !bus_err_i;
  assign miss_ack_o = miss_req_i && state_q == ST_IDLE && !reset_i;
  assign busy_o     = state_q != ST_IDLE;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      s_q          <= '0;
      k_q          <= '0;
      bus_req_q    <= 1'b0;
      bus_addr_q   <= '0;
      cw_valid_q   <= 1'b0;
      cw_data_q    <= '0;
      fill_valid_q <= 1'b0;
      fill_index_q <= '0;
      fill_err_q   <= 1'b0;
    end else begin
      cw_valid_q   <= 1'b0;
      fill_valid_q <= 1'b0;
      fill_err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: if (miss_req_i) begin
          state_q    <= ST_FETCH;
          addr_q     <= miss_addr_i[31:4];
          s_q        <= miss_addr_i[3:2];
          k_q        <= '0;
          bus_req_q  <= 1'b1;
          bus_addr_q <= miss_addr_i & 32'hFFFF_FFFC;
        end
        ST_FETCH: if (bus_ack_i) begin
          if (bus_err_i) begin
            state_q    <= ST_IDLE;
            bus_req_q  <= 1'b0;
            fill_err_q <= 1'b1;
          end else begin
            k_q        <= k_q + 2'd1;
            bus_addr_q <= {addr_q, off + 2'd1, 2'b00};
            if (k_q == 2'd0) begin
              cw_valid_q <= 1'b1;
              cw_data_q  <= bus_data_i;
            end
            if (k_q == 2'd3) begin
              state_q      <= ST_COMMIT;
              bus_req_q    <= 1'b0;
              fill_valid_q <= 1'b1;
              fill_index_q <= addr_q[7:0];
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  cache_line_assembler u_asm (
    .clk_i     (clk_i),
    .rst_i     (reset_i),
    .wr_en_i   (beat_ok),
    .wr_off_i  (off),
    .wr_data_i (bus_data_i),
    .commit_i  (beat_ok && k_q == 2'd3),
    .tag_i     (addr_q[27:8]),
    .line_o    (fill_line_o)
  );
  assign bus_req_o    = bus_req_q;
  assign bus_addr_o   = bus_addr_q;
  assign cw_valid_o   = cw_valid_q;
  assign cw_data_o    = cw_data_q;
  assign fill_valid_o = fill_valid_q;
  assign fill_index_o = fill_index_q;
  assign fill_err_o   = fill_err_q;
endmodule

// File: tb/tb_insn_line_fill.sv
// tb_insn_line_fill: table, hand-written and random refills checked against a wrap-order bus/line model
module tb_insn_line_fill;
  import cache_defs_pkg::*;
  logic              clk_i = 1'b0;
  logic              reset_i, miss_req_i, bus_ack_i, bus_err_i;
  logic [31:0]       miss_addr_i, bus_data_i;
  logic              miss_ack_o, busy_o, bus_req_o, cw_valid_o, fill_valid_o, fill_err_o;
  logic [31:0]       bus_addr_o, cw_data_o;
  logic [IDX_W-1:0]  fill_index_o;
  logic [LINE_W-1:0] fill_line_o;
  always #5 clk_i = ~clk_i;
  insn_line_fill dut (
    .clk_i(clk_i), .reset_i(reset_i), .miss_req_i(miss_req_i), .miss_addr_i(miss_addr_i),
    .miss_ack_o(miss_ack_o), .busy_o(busy_o), .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o),
    .bus_ack_i(bus_ack_i), .bus_data_i(bus_data_i), .bus_err_i(bus_err_i),
    .cw_valid_o(cw_valid_o), .cw_data_o(cw_data_o), .fill_valid_o(fill_valid_o),
    .fill_index_o(fill_index_o), .fill_line_o(fill_line_o), .fill_err_o(fill_err_o)
  );
  typedef struct {
    logic [31:0]      addr;
    int               w0, w1, w2, w3;
    int               eb;
    logic [31:0]      exp_first;
    logic [IDX_W-1:0] exp_idx;
    int               exp_at;
  } vec_t;
  vec_t              tbl[6];
  int                errors = 0, checks = 0;
  int                cyc, cw_n, cw_at, fv_n, fv_at, fe_n, fe_at, last_at;
  logic [31:0]       cw_v, first_ba;
  logic [LINE_W-1:0] fv_line, prev_line;
  logic [IDX_W-1:0]  fv_idx;
  logic [31:0]       d[4];
  int                w[4];
  task automatic chk(input string n, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk_i);
    cyc++;
    if (cw_valid_o) begin cw_n++; cw_at = cyc; cw_v = cw_data_o; end
    if (fill_valid_o) begin fv_n++; fv_at = cyc; fv_line = fill_line_o; fv_idx = fill_index_o; end
    if (fill_err_o) begin fe_n++; fe_at = cyc; end
  endtask
  task automatic start_miss(input logic [31:0] a);
    cyc = 0; cw_n = 0; fv_n = 0; fe_n = 0;
    miss_addr_i = a;
    miss_req_i = 1'b1;
    #1 chk("miss_ack", miss_ack_o, 1);
  endtask
  task automatic run_fill(input logic [31:0] a, input int eb, input bit hold, input bit cont);
    int wsum, nb;
    logic [1:0] off;
    logic [31:0] ea;
    if (!cont) tick();
    start_miss(a);
    wsum = 0;
    nb = eb < 0 ? 4 : eb + 1;
    for (int b = 0; b < nb; b++) begin
      off = 2'((a >> 2) + b);
      ea = (a & 32'hFFFF_FFF0) | (32'(off) << 2);
      for (int i = 0; i < w[b]; i++) begin
        tick();
        miss_req_i = hold; bus_ack_i = 1'b0; bus_err_i = 1'($urandom % 2);
        #1 chk("wait_req", bus_req_o, 1);
        chk("wait_addr", bus_addr_o, ea);
        if (hold) chk("held_ack", miss_ack_o, 0);
      end
      tick();
      miss_req_i = hold; bus_ack_i = 1'b1; bus_err_i = b == eb; bus_data_i = d[off];
      #1 chk("beat_req", bus_req_o, 1);
      chk("beat_addr", bus_addr_o, ea);
      if (hold) chk("held_ack", miss_ack_o, 0);
      if (b == 0) first_ba = bus_addr_o;
      wsum += w[b];
    end
    tick();
    bus_ack_i = 1'b0; bus_err_i = 1'b0;
    #1 chk("req_drop", bus_req_o, 0);
    chk("busy_after", busy_o, eb < 0);
    if (hold) chk("held_ack_commit", miss_ack_o, 0);
    tick();
    #1 if (hold) chk("ack_after_commit", miss_ack_o, 1);
    if (eb < 0) begin
      chk("fill_cnt", fv_n, 1);
      chk("fill_cycle", fv_at, 5 + wsum);
      chk("fill_line", fv_line, {a[31:12], 1'b1, d[0], d[1], d[2], d[3]});
      chk("fill_idx", fv_idx, a[11:4]);
      chk("err_cnt", fe_n, 0);
      chk("cw_cnt", cw_n, 1);
      chk("cw_cycle", cw_at, 2 + w[0]);
      chk("cw_data", cw_v, d[a[3:2]]);
      prev_line = fv_line;
      last_at = fv_at;
    end else begin
      chk("err_fill_cnt", fv_n, 0);
      chk("err_cnt", fe_n, 1);
      chk("err_cycle", fe_at, eb + 2 + wsum);
      chk("err_cw_cnt", cw_n, eb > 0);
      if (eb > 0) chk("err_cw_data", cw_v, d[a[3:2]]);
      chk("err_line_hold", fill_line_o, prev_line);
      chk("err_idle", busy_o, 0);
      last_at = fe_at;
    end
  endtask
  task automatic rand_data();
    for (int i = 0; i < 4; i++) d[i] = $urandom;
  endtask
  initial begin
    tbl[0] = '{32'h0001_2340, 0, 0, 0, 0, -1, 32'h0001_2340, 8'h34, 5};
    tbl[1] = '{32'h0001_2348, 0, 0, 0, 0, -1, 32'h0001_2348, 8'h34, 5};
    tbl[2] = '{32'hFFFF_FFFC, 1, 0, 2, 0, -1, 32'hFFFF_FFFC, 8'hFF, 8};
    tbl[3] = '{32'h0001_2344, 0, 0, 0, 0,  2, 32'h0001_2344, 8'hFF, 4};
    tbl[4] = '{32'h00AB_C004, 0, 3, 0, 0, -1, 32'h00AB_C004, 8'h00, 8};
    tbl[5] = '{32'h0001_2340, 2, 0, 0, 0,  0, 32'h0001_2340, 8'h00, 4};
    reset_i = 1'b1; miss_req_i = 1'b1; miss_addr_i = 32'h0001_2340;
    bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_data_i = '0;
    cyc = 0; cw_n = 0; fv_n = 0; fe_n = 0; prev_line = '0;
    tick();
    #1 chk("reset_beats_req", miss_ack_o, 0);
    chk("rst_bus_req", bus_req_o, 0);
    chk("rst_bus_addr", bus_addr_o, 0);
    chk("rst_cw_valid", cw_valid_o, 0);
    chk("rst_cw_data", cw_data_o, 0);
    chk("rst_fill_valid", fill_valid_o, 0);
    chk("rst_fill_err", fill_err_o, 0);
    chk("rst_fill_idx", fill_index_o, 0);
    chk("rst_fill_line", fill_line_o, 0);
    chk("rst_busy", busy_o, 0);
    reset_i = 1'b0; miss_req_i = 1'b0;
    for (int r = 0; r < 6; r++) begin
      w[0] = tbl[r].w0; w[1] = tbl[r].w1; w[2] = tbl[r].w2; w[3] = tbl[r].w3;
      rand_data();
      run_fill(tbl[r].addr, tbl[r].eb, 1'b0, 1'b0);
      chk("tbl_first_addr", first_ba, tbl[r].exp_first);
      chk("tbl_event_cycle", last_at, tbl[r].exp_at);
      chk("tbl_index", fill_index_o, tbl[r].exp_idx);
    end
    w = '{0, 0, 0, 0};
    rand_data();
    run_fill(32'h1000_0014, -1, 1'b1, 1'b0);
    rand_data();
    run_fill(32'h2000_002C, -1, 1'b0, 1'b1);
    tick();
    start_miss(32'h0001_2340);
    tick();
    miss_req_i = 1'b0; bus_ack_i = 1'b1; bus_data_i = 32'hA5A5_0001;
    tick();
    bus_ack_i = 1'b0; reset_i = 1'b1; miss_req_i = 1'b1;
    #1 chk("rst_mid_ack", miss_ack_o, 0);
    tick();
    reset_i = 1'b0; miss_req_i = 1'b0; bus_ack_i = 1'b1; bus_data_i = 32'hDEAD_BEEF;
    #1 chk("rst_mid_req", bus_req_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_cw_data", cw_data_o, 0);
    tick();
    bus_ack_i = 1'b0;
    #1 chk("late_ack_req", bus_req_o, 0);
    chk("late_ack_busy", busy_o, 0);
    chk("late_ack_line", fill_line_o, 0);
    tick();
    chk("rst_mid_fill", fv_n, 0);
    chk("rst_mid_err", fe_n, 0);
    chk("rst_mid_cw_cnt", cw_n, 1);
    chk("rst_mid_cw_at", cw_at, 2);
    prev_line = '0;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) w[i] = $urandom_range(0, 3);
      rand_data();
      run_fill($urandom, ($urandom % 5 == 0) ? int'($urandom % 4) : -1, 1'b0, 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
